// File: rtl/temperature_scan_scheduler.sv
// rtl/temperature_scan_scheduler.sv - round-robin scan of sensor channels through a shared temperature datapath
//
// Ports:
//   clk, rst             single clock, synchronous active-high reset
//   scanEnable           level; scans repeat back to back while high
//   sensorValues         raw 4-bit values, sensor i at [4i+3:4i]
//   lowTempAbnormality   low flag returned by the shared analyzer
//   highTempAbnormality  high flag returned by the shared analyzer
//   alarmClear           per-sensor clear of alarms and persistence counters
//   tempSensorValue      value presented to the shared calculator
//   sensorIndex          currently selected sensor
//   busy                 high whenever the scheduler is not idle
//   lowAlarm, highAlarm  sticky per-sensor alarms
//   alarmIrq             one-cycle pulse when any alarm bit rises
//   scanDone             one-cycle pulse after the last sensor is updated
//   flagConflict         sticky; both flags were sampled high together
module temperature_scan_scheduler #(
    parameter int NUM_SENSORS   = 4,
    parameter int SETTLE_CYCLES = 1,
    parameter int ABN_COUNT     = 3,
    localparam int IDX_W        = $clog2(NUM_SENSORS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     scanEnable,
    input  logic [4*NUM_SENSORS-1:0] sensorValues,
    input  logic                     lowTempAbnormality,
    input  logic                     highTempAbnormality,
    input  logic [NUM_SENSORS-1:0]   alarmClear,
    output logic [3:0]               tempSensorValue,
    output logic [IDX_W-1:0]         sensorIndex,
    output logic                     busy,
    output logic [NUM_SENSORS-1:0]   lowAlarm,
    output logic [NUM_SENSORS-1:0]   highAlarm,
    output logic                     alarmIrq,
    output logic                     scanDone,
    output logic                     flagConflict
);

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, UPDATE} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_SENSORS - 1);
    localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [3:0]       ABN_MAX     = 4'(ABN_COUNT);

    state_t                 state;
    state_t                 next_state;
    logic [3:0]             settle_cnt;
    logic                   low_s;
    logic                   high_s;
    logic [3:0]             low_cnt      [NUM_SENSORS];
    logic [3:0]             high_cnt     [NUM_SENSORS];
    logic [3:0]             low_cnt_nxt  [NUM_SENSORS];
    logic [3:0]             high_cnt_nxt [NUM_SENSORS];
    logic [NUM_SENSORS-1:0] low_alarm_nxt;
    logic [NUM_SENSORS-1:0] high_alarm_nxt;
    logic                   alarm_rise;
    logic                   last_sensor;
    logic [IDX_W-1:0]       next_idx;
    logic [3:0]             slice        [NUM_SENSORS];

    function automatic logic [3:0] sat_inc(input logic [3:0] c);
        return (c >= ABN_MAX) ? c : c + 4'd1;
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_SENSORS; i++) begin
            slice[i] = sensorValues[4*i +: 4];
        end
    end

    assign last_sensor = (sensorIndex == LAST_IDX);
    assign next_idx    = last_sensor ? '0 : sensorIndex + IDX_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        busy       = (state != IDLE);
        case (state)
            IDLE:    if (scanEnable) next_state = SETTLE;
            SETTLE:  if (settle_cnt == SETTLE_LAST) next_state = SAMPLE;
            SAMPLE:  next_state = UPDATE;
            UPDATE:  next_state = (!last_sensor || scanEnable) ? SETTLE : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Clears are applied first so that an UPDATE of the same sensor
    // overrides them; the clear of the sensor being updated is masked.
    always_comb begin
        low_cnt_nxt    = low_cnt;
        high_cnt_nxt   = high_cnt;
        low_alarm_nxt  = lowAlarm;
        high_alarm_nxt = highAlarm;
        for (int i = 0; i < NUM_SENSORS; i++) begin
            if (alarmClear[i] && !(state == UPDATE && sensorIndex == IDX_W'(i))) begin
                low_cnt_nxt[i]    = '0;
                high_cnt_nxt[i]   = '0;
                low_alarm_nxt[i]  = 1'b0;
                high_alarm_nxt[i] = 1'b0;
            end
        end
        if (state == UPDATE) begin
            if (high_s) begin
                high_cnt_nxt[sensorIndex] = sat_inc(high_cnt[sensorIndex]);
                low_cnt_nxt[sensorIndex]  = '0;
            end else if (low_s) begin
                low_cnt_nxt[sensorIndex]  = sat_inc(low_cnt[sensorIndex]);
                high_cnt_nxt[sensorIndex] = '0;
            end else begin
                low_cnt_nxt[sensorIndex]  = '0;
                high_cnt_nxt[sensorIndex] = '0;
            end
            // Only the step onto ABN_COUNT raises an alarm; a saturated
            // counter sitting at ABN_COUNT does not re-fire.
            if (high_cnt_nxt[sensorIndex] == ABN_MAX && high_cnt[sensorIndex] != ABN_MAX) begin
                high_alarm_nxt[sensorIndex] = 1'b1;
            end
            if (low_cnt_nxt[sensorIndex] == ABN_MAX && low_cnt[sensorIndex] != ABN_MAX) begin
                low_alarm_nxt[sensorIndex] = 1'b1;
            end
        end
        alarm_rise = |((low_alarm_nxt & ~lowAlarm) | (high_alarm_nxt & ~highAlarm));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            settle_cnt      <= '0;
            low_s           <= 1'b0;
            high_s          <= 1'b0;
            sensorIndex     <= '0;
            tempSensorValue <= '0;
            lowAlarm        <= '0;
            highAlarm       <= '0;
            alarmIrq        <= 1'b0;
            scanDone        <= 1'b0;
            flagConflict    <= 1'b0;
            for (int i = 0; i < NUM_SENSORS; i++) begin
                low_cnt[i]  <= '0;
                high_cnt[i] <= '0;
            end
        end else begin
            low_cnt   <= low_cnt_nxt;
            high_cnt  <= high_cnt_nxt;
            lowAlarm  <= low_alarm_nxt;
            highAlarm <= high_alarm_nxt;
            alarmIrq  <= alarm_rise;
            scanDone  <= (state == UPDATE) && last_sensor;

            if (state == SETTLE && next_state == SETTLE) begin
                settle_cnt <= settle_cnt + 4'd1;
            end else begin
                settle_cnt <= '0;
            end

            if (state == SAMPLE) begin
                low_s  <= lowTempAbnormality;
                high_s <= highTempAbnormality;
            end

            if (state == UPDATE && high_s && low_s) begin
                flagConflict <= 1'b1;
            end

            // The selected value is captured on entry to SETTLE and held
            // through SAMPLE and UPDATE so the datapath sees a stable input.
            if (state == IDLE && scanEnable) begin
                sensorIndex     <= '0;
                tempSensorValue <= slice[0];
            end else if (state == UPDATE) begin
                sensorIndex <= next_idx;
                if (next_state == SETTLE) begin
                    tempSensorValue <= slice[next_idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_temperature_scan_scheduler.sv
// tb/tb_temperature_scan_scheduler.sv - directed table-driven bench for temperature_scan_scheduler
module tb_temperature_scan_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        scanEnable;
    logic [15:0] sensorValues;
    logic        lowTempAbnormality;
    logic        highTempAbnormality;
    logic [3:0]  alarmClear;
    logic [3:0]  tempSensorValue;
    logic [1:0]  sensorIndex;
    logic        busy;
    logic [3:0]  lowAlarm;
    logic [3:0]  highAlarm;
    logic        alarmIrq;
    logic        scanDone;
    logic        flagConflict;

    always #5 clk = ~clk;

    temperature_scan_scheduler #(
        .NUM_SENSORS  (4),
        .SETTLE_CYCLES(2),
        .ABN_COUNT    (3)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .scanEnable         (scanEnable),
        .sensorValues       (sensorValues),
        .lowTempAbnormality (lowTempAbnormality),
        .highTempAbnormality(highTempAbnormality),
        .alarmClear         (alarmClear),
        .tempSensorValue    (tempSensorValue),
        .sensorIndex        (sensorIndex),
        .busy               (busy),
        .lowAlarm           (lowAlarm),
        .highAlarm          (highAlarm),
        .alarmIrq           (alarmIrq),
        .scanDone           (scanDone),
        .flagConflict       (flagConflict)
    );

    typedef struct {
        logic [3:0] low_m;
        logic [3:0] high_m;
        logic [3:0] clr;
        int         clr_off;
        logic [3:0] exp_low;
        logic [3:0] exp_high;
        logic       exp_conf;
        int         exp_irq;
        int         exp_done;
    } row_t;

    row_t       tbl [13];
    logic [3:0] vals [4];
    int checks = 0;
    int errors = 0;
    int cyc;
    int irq_cnt;
    int done_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One scan cycle: flags follow the sensor the bench expects to be selected.
    task automatic do_cycle(input logic [3:0] low_m, input logic [3:0] high_m, input logic [3:0] clr);
        int s;
        s = (cyc / 4) % 4;
        lowTempAbnormality  = low_m[s];
        highTempAbnormality = high_m[s];
        alarmClear          = clr;
        tick();
        if (alarmIrq) irq_cnt++;
        if (scanDone) done_cnt++;
        cyc++;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " temp"}, 32'(tempSensorValue), 32'h0);
        check({tag, " idx"}, 32'(sensorIndex), 32'h0);
        check({tag, " busy"}, 32'(busy), 32'h0);
        check({tag, " lowAlarm"}, 32'(lowAlarm), 32'h0);
        check({tag, " highAlarm"}, 32'(highAlarm), 32'h0);
        check({tag, " alarmIrq"}, 32'(alarmIrq), 32'h0);
        check({tag, " scanDone"}, 32'(scanDone), 32'h0);
        check({tag, " flagConflict"}, 32'(flagConflict), 32'h0);
    endtask

    initial begin
        //            low      high     clr      off  exp_low  exp_high conf irq done
        tbl[0]  = '{4'b0010, 4'b0100, 4'b0000, 0,  4'b0000, 4'b0000, 1'b0, 0, 1};
        tbl[1]  = '{4'b0010, 4'b0100, 4'b0000, 0,  4'b0000, 4'b0000, 1'b0, 0, 1};
        tbl[2]  = '{4'b0000, 4'b0100, 4'b0000, 0,  4'b0000, 4'b0100, 1'b0, 1, 1};
        tbl[3]  = '{4'b0010, 4'b0100, 4'b0000, 0,  4'b0000, 4'b0100, 1'b0, 0, 1};
        tbl[4]  = '{4'b0010, 4'b0100, 4'b0000, 0,  4'b0000, 4'b0100, 1'b0, 0, 1};
        tbl[5]  = '{4'b0010, 4'b0100, 4'b0000, 0,  4'b0010, 4'b0100, 1'b0, 1, 1};
        tbl[6]  = '{4'b0000, 4'b0100, 4'b0100, 11, 4'b0010, 4'b0100, 1'b0, 0, 1};
        tbl[7]  = '{4'b0000, 4'b0100, 4'b0110, 0,  4'b0000, 4'b0000, 1'b0, 0, 1};
        tbl[8]  = '{4'b0000, 4'b0100, 4'b0000, 0,  4'b0000, 4'b0000, 1'b0, 0, 1};
        tbl[9]  = '{4'b0000, 4'b0100, 4'b0000, 0,  4'b0000, 4'b0100, 1'b0, 1, 1};
        tbl[10] = '{4'b0001, 4'b0101, 4'b0000, 0,  4'b0000, 4'b0100, 1'b1, 0, 1};
        tbl[11] = '{4'b0001, 4'b0101, 4'b0000, 0,  4'b0000, 4'b0100, 1'b1, 0, 1};
        tbl[12] = '{4'b0001, 4'b0101, 4'b0000, 0,  4'b0000, 4'b0101, 1'b1, 1, 1};
        vals[0] = 4'h1; vals[1] = 4'h5; vals[2] = 4'h9; vals[3] = 4'hD;

        rst                 = 1'b1;
        scanEnable          = 1'b0;
        sensorValues        = {4'hD, 4'h9, 4'h5, 4'h1};
        lowTempAbnormality  = 1'b0;
        highTempAbnormality = 1'b0;
        alarmClear          = 4'b0000;
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();
        check("idle busy", 32'(busy), 32'h0);

        // Scan timing: each value held 4 cycles, scanDone 16 cycles after leaving IDLE.
        scanEnable = 1'b1;
        tick();
        check("entry temp", 32'(tempSensorValue), 32'h1);
        check("entry busy", 32'(busy), 32'h1);
        cyc      = 0;
        irq_cnt  = 0;
        done_cnt = 0;
        for (int c = 0; c < 16; c++) begin
            do_cycle(4'b0000, 4'b0000, 4'b0000);
            check($sformatf("scan1 temp c%0d", c), 32'(tempSensorValue), 32'(vals[((c + 1) / 4) % 4]));
            check($sformatf("scan1 idx c%0d", c), 32'(sensorIndex), 32'(((c + 1) / 4) % 4));
            check($sformatf("scan1 done c%0d", c), 32'(scanDone), 32'(c == 15));
        end
        check("scan1 irq count", 32'(irq_cnt), 32'h0);
        check("scan1 alarms", 32'({lowAlarm, highAlarm}), 32'h0);

        // Back-to-back scans driven from the table.
        for (int r = 0; r < 13; r++) begin
            irq_cnt  = 0;
            done_cnt = 0;
            for (int off = 0; off < 16; off++) begin
                do_cycle(tbl[r].low_m, tbl[r].high_m, (off == tbl[r].clr_off) ? tbl[r].clr : 4'b0000);
            end
            check($sformatf("row%0d lowAlarm", r), 32'(lowAlarm), 32'(tbl[r].exp_low));
            check($sformatf("row%0d highAlarm", r), 32'(highAlarm), 32'(tbl[r].exp_high));
            check($sformatf("row%0d flagConflict", r), 32'(flagConflict), 32'(tbl[r].exp_conf));
            check($sformatf("row%0d irq count", r), 32'(irq_cnt), 32'(tbl[r].exp_irq));
            check($sformatf("row%0d done count", r), 32'(done_cnt), 32'(tbl[r].exp_done));
        end

        // scanEnable dropped during sensor 1 SETTLE: scan completes, then IDLE.
        irq_cnt  = 0;
        done_cnt = 0;
        for (int off = 0; off < 16; off++) begin
            if (off == 4) scanEnable = 1'b0;
            do_cycle(4'b0000, 4'b0000, 4'b0000);
            if (off == 7) begin
                check("stop s2 temp", 32'(tempSensorValue), 32'h9);
                check("stop s2 idx", 32'(sensorIndex), 32'h2);
            end
            if (off == 11) begin
                check("stop s3 temp", 32'(tempSensorValue), 32'hD);
                check("stop s3 idx", 32'(sensorIndex), 32'h3);
            end
            if (off == 14) check("stop busy in UPDATE", 32'(busy), 32'h1);
        end
        check("stop done count", 32'(done_cnt), 32'h1);
        check("stop busy after", 32'(busy), 32'h0);
        check("stop idx wrap", 32'(sensorIndex), 32'h0);
        for (int k = 0; k < 5; k++) tick();
        check("stop idle busy", 32'(busy), 32'h0);
        check("stop idle done", 32'(scanDone), 32'h0);

        // Reset pulsed during SAMPLE of sensor 3.
        scanEnable = 1'b1;
        tick();
        cyc      = 0;
        irq_cnt  = 0;
        done_cnt = 0;
        for (int off = 0; off < 14; off++) do_cycle(4'b0000, 4'b0000, 4'b0000);
        check("pre-rst highAlarm", 32'(highAlarm), 32'h5);
        check("pre-rst flagConflict", 32'(flagConflict), 32'h1);
        check("pre-rst idx", 32'(sensorIndex), 32'h3);
        rst = 1'b1;
        do_cycle(4'b0000, 4'b0000, 4'b0000);
        check_all_zero("mid-scan rst");
        rst        = 1'b0;
        scanEnable = 1'b0;
        for (int k = 0; k < 10; k++) do_cycle(4'b0000, 4'b0000, 4'b0000);
        check("post-rst done count", 32'(done_cnt), 32'h0);
        check("post-rst irq count", 32'(irq_cnt), 32'h0);
        check("post-rst busy", 32'(busy), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
